// File: rtl/reg_file.sv
// MIPS32 general-purpose register file: two combinational read ports, one
// synchronous write port, $0 hard-wired to zero, optional write-to-read bypass.
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    // regs[0] is re-cleared every edge so an unknown we/waddr can never leave it non-zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[0] <= '0;
            if (we && waddr != '0) begin
                regs[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (reset || raddr1 == '0) begin
            rdata1 = '0;
        end else if (BYPASS && we && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (reset || raddr2 == '0) begin
            rdata2 = '0;
        end else if (BYPASS && we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

    always_comb begin
        dbg_data = regs[dbg_addr];
        if (reset || dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

endmodule
